// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for the MIPS core
package pipe_pkg;

  localparam int REG_W = 5;
  localparam int WB_W  = 2;
  localparam int MEM_W = 2;
  localparam int EX_W  = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {RUN, BUSY} state_e;

  // Control bundle carried in ID/EX; id_ex_flush zeroes all of it.
  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use comparison between the load in EX and the reader in ID
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_o
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with MDU occupancy tracking
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_mdu,
  input  logic             id_reads_hilo,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ext_stall,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             mdu_start,
  output logic             mdu_busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MDU_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu, mh, stall;

  load_use_detect u_lu (
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .lu_o          (lu)
  );

  assign mh    = (state_q == BUSY) && (id_is_mdu || id_reads_hilo);
  assign stall = lu || mh;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    mdu_start   = 1'b0;
    if (rst || ext_stall) begin
      // frozen: nothing moves
    end else if (stall) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      if_id_flush = branch_taken;
      mdu_start   = id_is_mdu;
    end
  end

  assign mdu_busy = !rst && (state_q == BUSY);

  // The MDU runs on its own, so the counter advances even under ext_stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mdu_start) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (MDU_LAT=4 and MDU_LAT=1)
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       ext_stall;
    logic       branch_taken;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_is_mdu;
    logic       id_reads_hilo;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] e0;
    logic [6:0] e1;
  } sb_t;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, mdu_start, mdu_busy}
  localparam logic [6:0] O_ZERO  = 7'b0000000;
  localparam logic [6:0] O_RUN   = 7'b1101000;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_STALL = 7'b0001100;
  localparam logic [6:0] O_STLB  = 7'b0001101;
  localparam logic [6:0] O_START = 7'b1101010;
  localparam logic [6:0] O_BRUN  = 7'b1101001;
  localparam logic [6:0] O_FRZB  = 7'b0000001;

  logic       clk;
  logic       rst, ext_stall, branch_taken, ex_mem_read;
  logic       id_uses_rt, id_is_mdu, id_reads_hilo;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_flush0, mdu_start0, mdu_busy0;
  logic       pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, mdu_start1, mdu_busy1;
  logic [6:0] got0, got1;

  int total = 0;
  int bad   = 0;
  sb_t sbq[$];
  vec_t tbl[14];

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo), .branch_taken(branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ext_stall(ext_stall),
    .pc_en(pc_en0), .if_id_en(if_id_en0), .if_id_flush(if_id_flush0), .id_ex_en(id_ex_en0),
    .id_ex_flush(id_ex_flush0), .mdu_start(mdu_start0), .mdu_busy(mdu_busy0)
  );

  hazard_ctrl #(.MDU_LAT(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo), .branch_taken(branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ext_stall(ext_stall),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1), .id_ex_en(id_ex_en1),
    .id_ex_flush(id_ex_flush1), .mdu_start(mdu_start1), .mdu_busy(mdu_busy1)
  );

  assign got0 = {pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_flush0, mdu_start0, mdu_busy0};
  assign got1 = {pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, mdu_start1, mdu_busy1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic r, input logic xs, input logic br, input logic mr,
                             input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urt, input logic mdu, input logic hilo);
    in_t v;
    v.rst = r; v.ext_stall = xs; v.branch_taken = br; v.ex_mem_read = mr;
    v.ex_rt = ert; v.id_rs = rs; v.id_rt = rt; v.id_uses_rt = urt;
    v.id_is_mdu = mdu; v.id_reads_hilo = hilo;
    return v;
  endfunction

  task automatic check();
    sb_t s;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    s = sbq.pop_front();
    total++;
    if (got0 !== s.e0) begin
      bad++;
      $display("FAIL %s lat4: got %b want %b", s.name, got0, s.e0);
    end
    total++;
    if (got1 !== s.e1) begin
      bad++;
      $display("FAIL %s lat1: got %b want %b", s.name, got1, s.e1);
    end
  endtask

  task automatic step(input string name, input in_t v, input logic [6:0] e0, input logic [6:0] e1);
    sb_t s;
    rst = v.rst; ext_stall = v.ext_stall; branch_taken = v.branch_taken;
    ex_mem_read = v.ex_mem_read; ex_rt = v.ex_rt; id_rs = v.id_rs; id_rt = v.id_rt;
    id_uses_rt = v.id_uses_rt; id_is_mdu = v.id_is_mdu; id_reads_hilo = v.id_reads_hilo;
    s.name = name; s.e0 = e0; s.e1 = e1;
    sbq.push_back(s);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t z;
    z = mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    rst = 1'b1; ext_stall = 0; branch_taken = 0; ex_mem_read = 0; ex_rt = 0;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_mdu = 0; id_reads_hilo = 0;

    tbl[0]  = '{"reset",       mk(1, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1), O_ZERO};
    tbl[1]  = '{"idle",        z,                                          O_RUN};
    tbl[2]  = '{"lu_rs",       mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0), O_STALL};
    tbl[3]  = '{"lu_after",    mk(0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0, 0), O_RUN};
    tbl[4]  = '{"lu_r0",       mk(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0), O_RUN};
    tbl[5]  = '{"rt_unused",   mk(0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0), O_RUN};
    tbl[6]  = '{"lu_rt",       mk(0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0), O_STALL};
    tbl[7]  = '{"no_load",     mk(0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 0, 0), O_RUN};
    tbl[8]  = '{"branch",      mk(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_BR};
    tbl[9]  = '{"branch_lu",   mk(0, 0, 1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0), O_STALL};
    tbl[10] = '{"branch_held", mk(0, 0, 1, 0, 5'd0, 5'd7, 5'd0, 0, 0, 0), O_BR};
    tbl[11] = '{"ext_br_lu",   mk(0, 1, 1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0), O_ZERO};
    tbl[12] = '{"ext_mdu_run", mk(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_ZERO};
    tbl[13] = '{"hilo_run",    mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_RUN};

    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].name, tbl[i].in, tbl[i].exp, tbl[i].exp);
    end

    // mult at t, add at t+1, mflo waits (one cycle also carrying a load-use)
    step("mdu_issue",  mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_START, O_START);
    step("mdu_add",    mk(0, 0, 0, 0, 5'd0, 5'd3, 5'd4, 1, 0, 0), O_BRUN,  O_BRUN);
    step("mflo_t2",    mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_STLB,  O_RUN);
    step("mflo_lu_t3", mk(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1), O_STLB,  O_STALL);
    step("mflo_t4",    mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_STLB,  O_RUN);
    step("mflo_t5",    mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_RUN,   O_RUN);

    // ext_stall for 3 cycles while busy, with a second mult waiting in ID
    step("ext_issue",  mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_START, O_START);
    step("ext_s1",     mk(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_FRZB,  O_FRZB);
    step("ext_s2",     mk(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_FRZB,  O_ZERO);
    step("ext_s3",     mk(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_FRZB,  O_ZERO);
    step("ext_s4",     mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_STLB,  O_START);
    step("ext_s5",     mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_START, O_STLB);

    // reset while busy with cnt=2 abandons the operation
    step("rst_pre",    z,                                          O_BRUN,  O_RUN);
    step("rst_busy",   mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_ZERO,  O_ZERO);
    step("rst_after",  mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_RUN,   O_RUN);
    step("rst_idle",   z,                                          O_RUN,   O_RUN);

    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
